ibex_rvfi_trace_buffer: RTL

//  Parametrised retirement-trace capture buffer fed by the core's RVFI retirement port (rvfi_valid,

---
 rtl/ibex_rvfi_trace_buffer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ibex_rvfi_trace_buffer.sv
// ibex_rvfi_trace_buffer
//   Retirement-trace capture buffer fed from the RVFI retirement port. Keeps
//   the last Depth retired records in a circular memory. When the buffer is
//   full it either overwrites the oldest record (wrap mode) or discards the
//   new one. An optional PC-match trigger freezes capture PostTrig records
//   after the matching retirement. Records are drained through a valid/ready
//   read port.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   arm_i, clear_i          control pulses (arm capture / flush everything)
//   wrap_mode_i             1 = overwrite oldest when full, 0 = drop new
//   trig_en_i, trig_pc_i    PC-match trigger enable and address
//   rvfi_*                  retirement record inputs
//   rd_valid_o/rd_ready_i   read handshake, rd_record_o is the head entry
//                           {trap, intr, rd_addr, pc, insn, rd_wdata}
//   count_o, drop_cnt_o     occupancy and saturating lost-record count
//   state_o, triggered_o    0 IDLE, 1 ARMED, 2 POST, 3 FROZEN; trigger seen
module ibex_rvfi_trace_buffer #(
  parameter int unsigned Depth    = 16,
  parameter int unsigned PostTrig = 4,
  parameter int unsigned DropW    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       arm_i,
  input  logic                       clear_i,
  input  logic                       wrap_mode_i,
  input  logic                       trig_en_i,
  input  logic [31:0]                trig_pc_i,
  input  logic                       rvfi_valid,
  input  logic [31:0]                rvfi_pc_rdata,
  input  logic [31:0]                rvfi_insn,
  input  logic [4:0]                 rvfi_rd_addr,
  input  logic [31:0]                rvfi_rd_wdata,
  input  logic                       rvfi_trap,
  input  logic                       rvfi_intr,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [102:0]               rd_record_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic [DropW-1:0]           drop_cnt_o,
  output logic [1:0]                 state_o,
  output logic                       triggered_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = $clog2(Depth + 1);
  localparam logic [AW-1:0] PostInit = AW'(PostTrig);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    POST   = 2'd2,
    FROZEN = 2'd3
  } state_e;

  state_e           r_state;
  logic [AW-1:0]    r_post_cnt;
  logic             r_triggered;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [DropW-1:0] r_drop;
  logic [102:0]     r_mem [Depth];

  logic [102:0] w_record;
  logic         w_full;
  logic         w_capture;
  logic         w_pop;
  logic         w_lost;
  logic         w_write;
  logic         w_rd_adv;
  logic         w_trig_hit;

  assign w_record   = {rvfi_trap, rvfi_intr, rvfi_rd_addr, rvfi_pc_rdata,
                       rvfi_insn, rvfi_rd_wdata};
  assign w_full     = (r_count == CW'(Depth));
  // clear_i wins over everything, so it masks both capture and pop.
  assign w_capture  = rvfi_valid & ((r_state == ARMED) | (r_state == POST)) & ~clear_i;
  assign w_pop      = (r_count != '0) & rd_ready_i & ~clear_i;
  // A capture into a full buffer with no simultaneous pop loses a record:
  // either the oldest (wrap mode) or the new one (stop mode).
  assign w_lost     = w_capture & w_full & ~w_pop;
  assign w_write    = w_capture & (~w_full | w_pop | wrap_mode_i);
  // The read pointer also moves when wrap mode overwrites the head.
  assign w_rd_adv   = w_pop | (w_lost & wrap_mode_i);
  assign w_trig_hit = w_capture & trig_en_i & (rvfi_pc_rdata == trig_pc_i);

  // Record storage has no reset; rd_record_o is only meaningful while
  // rd_valid_o is high.
  always_ff @(posedge clk_i) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= w_record;
    end
  end

  // Pointers, occupancy and dropped-record counter. Depth is a power of two,
  // so the pointers wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_adv) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_capture & ~w_full & ~w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop & ~w_capture) begin
        r_count <= r_count - CW'(1);
      end
      if (w_lost & ~(&r_drop)) begin
        r_drop <= r_drop + DropW'(1);
      end
    end
  end

  // Capture-control FSM. Dropped captures still advance the post-trigger
  // countdown, since they are still retirements after the trigger.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_post_cnt  <= '0;
      r_triggered <= 1'b0;
    end else if (clear_i) begin
      r_state     <= IDLE;
      r_post_cnt  <= '0;
      r_triggered <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (arm_i) begin
            r_state <= ARMED;
          end
        end
        ARMED: begin
          if (w_trig_hit) begin
            r_post_cnt  <= PostInit;
            r_triggered <= 1'b1;
            r_state     <= (PostTrig == 0) ? FROZEN : POST;
          end
        end
        POST: begin
          if (w_capture) begin
            if (r_post_cnt == AW'(1)) begin
              r_state <= FROZEN;
            end
            r_post_cnt <= r_post_cnt - AW'(1);
          end
        end
        FROZEN: begin
          if (arm_i) begin
            r_state     <= ARMED;
            r_triggered <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rd_record_o = r_mem[r_rd_ptr];
  assign rd_valid_o  = (r_count != '0);
  assign count_o     = r_count;
  assign drop_cnt_o  = r_drop;
  assign state_o     = r_state;
  assign triggered_o = r_triggered;

endmodule
